// File: rtl/prog_2_2_pkg.sv
// Shared constants and helpers for the prog_2_2 truth-table block.
package prog_2_2_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned TT_W  = 16;
  localparam int unsigned CNT_W = 8;

  localparam logic [TT_W-1:0]  F_TT_DEFAULT = 16'hA5A5;
  localparam logic [TT_W-1:0]  G_TT_DEFAULT = 16'hF888;
  localparam logic [CNT_W-1:0] CNT_MAX      = 8'hFF;

  // Table index with a as the most significant bit.
  function automatic logic [IDX_W-1:0] tt_idx(input logic a, input logic b,
                                                input logic c, input logic d);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/prog_2_2_if.sv
// Function-input / result bundle for prog_2_2; fg_cnt exists only with PROG_2_2_STATUS_EN.
interface prog_2_2_if;
  import prog_2_2_pkg::*;

  logic a;
  logic b;
  logic c;
  logic d;
  logic f;
  logic g;
`ifdef PROG_2_2_STATUS_EN
  logic [CNT_W-1:0] fg_cnt;

  modport master (output a, b, c, d, input f, g, fg_cnt);
  modport slave  (input a, b, c, d, output f, g, fg_cnt);
`else
  modport master (output a, b, c, d, input f, g);
  modport slave  (input a, b, c, d, output f, g);
`endif

endinterface

// File: rtl/prog_2_2_lut4.sv
// Combinational 4-input lookup: y_c = TT[idx].
module lut4
  import prog_2_2_pkg::*;
#(
  parameter logic [TT_W-1:0] TT = 16'h0000
) (
  input  logic [IDX_W-1:0] idx,
  output logic             y_c
);

  assign y_c = TT[idx];

endmodule

// File: rtl/prog_2_2.sv
// Registered f/g truth-table outputs; optional saturating f&g cycle counter under PROG_2_2_STATUS_EN.
module prog_2_2
  import prog_2_2_pkg::*;
#(
  parameter logic [TT_W-1:0] F_TT = F_TT_DEFAULT,
  parameter logic [TT_W-1:0] G_TT = G_TT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  prog_2_2_if.slave  bus
);

  logic [IDX_W-1:0] idx_c;
  logic             f_c;
  logic             g_c;
  logic             f_q;
  logic             g_q;

  assign idx_c = tt_idx(bus.a, bus.b, bus.c, bus.d);

  lut4 #(.TT(F_TT)) u_lut_f (.idx(idx_c), .y_c(f_c));
  lut4 #(.TT(G_TT)) u_lut_g (.idx(idx_c), .y_c(g_c));

  // Output flops: the only path from inputs to f/g.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= 1'b0;
      g_q <= 1'b0;
    end else begin
      f_q <= f_c;
      g_q <= g_c;
    end
  end

  assign bus.f = f_q;
  assign bus.g = g_q;

`ifdef PROG_2_2_STATUS_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts edges where the registered f and g are both high; sticks at CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (f_q && g_q && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.fg_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prog_2_2.sv
// Directed self-checking bench for prog_2_2 (default and overridden tables).
`timescale 1ns/1ps
module tb_prog_2_2;
  import prog_2_2_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  prog_2_2_if bus_d ();
  prog_2_2_if bus_o ();

  prog_2_2 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_d.slave)
  );

  prog_2_2 #(.F_TT(16'h0001), .G_TT(16'h8000)) u_dut_ovr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idx(input logic [3:0] v);
    {bus_d.a, bus_d.b, bus_d.c, bus_d.d} = v;
    {bus_o.a, bus_o.b, bus_o.c, bus_o.d} = v;
  endtask

  // Hand-listed minterms of the default tables.
  function automatic logic f_exp(input int i);
    case (i)
      0, 2, 5, 7, 8, 10, 13, 15: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic g_exp(input int i);
    case (i)
      3, 7, 11, 12, 13, 14, 15: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_idx(4'b1111);

    // Reset held across edges with all inputs high
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_f_%0d", k), 32'(bus_d.f), 32'd0);
      check_eq($sformatf("rst_g_%0d", k), 32'(bus_d.g), 32'd0);
`ifdef PROG_2_2_STATUS_EN
      check_eq($sformatf("rst_cnt_%0d", k), 32'(bus_d.fg_cnt), 32'd0);
`endif
    end
    rst_n = 1'b1;

    // Full index sweep, both default and overridden tables
    for (int i = 0; i < 16; i++) begin
      set_idx(4'(i));
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("sweep_f_%0d", i), 32'(bus_d.f), 32'(f_exp(i)));
      check_eq($sformatf("sweep_g_%0d", i), 32'(bus_d.g), 32'(g_exp(i)));
      check_eq($sformatf("ovr_f_%0d", i), 32'(bus_o.f), (i == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("ovr_g_%0d", i), 32'(bus_o.g), (i == 15) ? 32'd1 : 32'd0);
    end

    // Mid-cycle input change must wait for the next edge
    set_idx(4'd0);
    @(posedge clk);
    #2;
    check_eq("lat_f_idx0", 32'(bus_d.f), 32'd1);
    check_eq("lat_g_idx0", 32'(bus_d.g), 32'd0);
    set_idx(4'd3);
    #2;
    check_eq("lat_f_hold", 32'(bus_d.f), 32'd1);
    check_eq("lat_g_hold", 32'(bus_d.g), 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_f_idx3", 32'(bus_d.f), 32'd0);
    check_eq("lat_g_idx3", 32'(bus_d.g), 32'd1);

    // Asynchronous reset between edges
    set_idx(4'd15);
    @(posedge clk);
    #1;
    check_eq("arst_f_pre", 32'(bus_d.f), 32'd1);
    check_eq("arst_g_pre", 32'(bus_d.g), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_f_post", 32'(bus_d.f), 32'd0);
    check_eq("arst_g_post", 32'(bus_d.g), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PROG_2_2_STATUS_EN
    // Counter lags the registered outputs by one edge, then saturates
    set_idx(4'd15);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("cnt_10_edges", 32'(bus_d.fg_cnt), 32'd9);
    repeat (290) @(posedge clk);
    @(negedge clk);
    check_eq("cnt_sat", 32'(bus_d.fg_cnt), 32'd255);
    set_idx(4'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("cnt_hold", 32'(bus_d.fg_cnt), 32'd255);
    check_eq("cnt_hold_f", 32'(bus_d.f), 32'd1);
    check_eq("cnt_hold_g", 32'(bus_d.g), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
